// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Decodes PC/FD/DX/XM/MW write enables and squash controls from the FSM state
// plus the current hazard inputs (Mealy), and runs the multdiv start/wait
// handshake with a wait-timeout watchdog.
// Optional feature macro: STALL_PERF_EN adds the stall_cycles/flush_count
// performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  fd_rs1,
    input  logic [4:0]  fd_rs2,
    input  logic        fd_uses_rs1,
    input  logic        fd_uses_rs2,
    input  logic [4:0]  dx_rd,
    input  logic        dx_is_load,
    input  logic        dx_is_multdiv,
    input  logic        br_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        md_start,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        dx_wren,
    output logic        xm_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        dx_bubble,
    output logic        xm_bubble,
`ifdef STALL_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        md_timeout
);

    localparam int unsigned REG_W = 5;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   wcnt;
    logic [CNT_W-1:0]   wcnt_n;
    logic               load_use_c;
    logic               wcnt_last_c;

    // Load-use hazard: a load in DX writes a register the FD instruction reads.
    assign load_use_c = dx_is_load && (dx_rd != REG_W'(0)) &&
                        ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                         (fd_uses_rs2 && (fd_rs2 == dx_rd)));

    // Last permitted wait cycle before the watchdog forces a release.
    assign wcnt_last_c = (wcnt == CNT_W'(MD_TIMEOUT - 1));

    // State and wait counter; reset aborts any multdiv wait in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // Next-state and Mealy output decode; reset cycle presents the free-run outputs.
    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        md_start   = 1'b0;
        pc_wren    = 1'b1;
        fd_wren    = 1'b1;
        dx_wren    = 1'b1;
        xm_wren    = 1'b1;
        mw_wren    = 1'b1;
        fd_flush   = 1'b0;
        dx_bubble  = 1'b0;
        xm_bubble  = 1'b0;
        md_timeout = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (dx_is_multdiv) begin
                        md_start  = 1'b1;
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        dx_wren   = 1'b0;
                        xm_bubble = 1'b1;
                        state_n   = MD_WAIT;
                        wcnt_n    = '0;
                    end else if (br_taken) begin
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (load_use_c) begin
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_ready || md_exception || wcnt_last_c) begin
                        // Release: every latch advances so XM captures the result.
                        md_timeout = wcnt_last_c && !md_ready && !md_exception;
                        state_n    = RUN;
                        wcnt_n     = '0;
                    end else begin
                        // Hold front end, drain older instructions through XM/MW.
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        dx_wren   = 1'b0;
                        xm_bubble = 1'b1;
                        wcnt_n    = wcnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_wren && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (fd_flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed vectors with hand-computed
// expected output words, checked by a scoreboard monitor on the falling edge.
// Two instances share the inputs: MD_TIMEOUT=64 (main) and MD_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

    // Output word: {md_start, pc, fd, dx, xm, mw wren, fd_flush, dx_bubble, xm_bubble, md_timeout}
    localparam logic [9:0] O_RUN = 10'b0_11111_000_0;
    localparam logic [9:0] O_LU  = 10'b0_00111_010_0;
    localparam logic [9:0] O_BR  = 10'b0_11111_110_0;
    localparam logic [9:0] O_MDS = 10'b1_00011_001_0;
    localparam logic [9:0] O_MDW = 10'b0_00011_001_0;
    localparam logic [9:0] O_REL = 10'b0_11111_000_0;
    localparam logic [9:0] O_TO  = 10'b0_11111_000_1;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] fd_rs1, fd_rs2, dx_rd;
    logic       fd_uses_rs1, fd_uses_rs2, dx_is_load, dx_is_multdiv;
    logic       br_taken, md_ready, md_exception;

    logic       a_start, a_pc, a_fd, a_dx, a_xm, a_mw, a_fl, a_dxb, a_xmb, a_to;
    logic       b_start, b_pc, b_fd, b_dx, b_xm, b_mw, b_fl, b_dxb, b_xmb, b_to;
`ifdef STALL_PERF_EN
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

    typedef struct {
        logic       sel;
        logic [9:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(7)) u_dut (
        .clock(clock), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
        .br_taken(br_taken), .md_ready(md_ready), .md_exception(md_exception),
        .md_start(a_start), .pc_wren(a_pc), .fd_wren(a_fd), .dx_wren(a_dx),
        .xm_wren(a_xm), .mw_wren(a_mw), .fd_flush(a_fl), .dx_bubble(a_dxb),
        .xm_bubble(a_xmb),
`ifdef STALL_PERF_EN
        .stall_cycles(a_stall), .flush_count(a_flush),
`endif
        .md_timeout(a_to)
    );

    pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) u_dut8 (
        .clock(clock), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
        .br_taken(br_taken), .md_ready(md_ready), .md_exception(md_exception),
        .md_start(b_start), .pc_wren(b_pc), .fd_wren(b_fd), .dx_wren(b_dx),
        .xm_wren(b_xm), .mw_wren(b_mw), .fd_flush(b_fl), .dx_bubble(b_dxb),
        .xm_bubble(b_xmb),
`ifdef STALL_PERF_EN
        .stall_cycles(b_stall), .flush_count(b_flush),
`endif
        .md_timeout(b_to)
    );

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic step(input logic rst, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic md, input logic br, input logic rdy,
                        input logic exc, input logic sel,
                        input logic [9:0] exp, input string tag);
        sb_t e;
        @(posedge clock);
        #1;
        reset         = rst;
        dx_is_load    = ld;
        dx_rd         = rd;
        fd_rs1        = rs1;
        fd_uses_rs1   = u1;
        fd_rs2        = rs2;
        fd_uses_rs2   = u2;
        dx_is_multdiv = md;
        br_taken      = br;
        md_ready      = rdy;
        md_exception  = exc;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Shorthand for multdiv-related cycles with no register hazard.
    task automatic mcyc(input logic rst, input logic md, input logic br,
                        input logic rdy, input logic exc, input logic sel,
                        input logic [9:0] exp, input string tag);
        step(rst, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, md, br, rdy, exc, sel, exp, tag);
    endtask

    // Monitor: pop one expectation per cycle and compare against the selected instance.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_t        e;
            logic [9:0] act;
            e = sb_q.pop_front();
            if (e.sel)
                act = {b_start, b_pc, b_fd, b_dx, b_xm, b_mw, b_fl, b_dxb, b_xmb, b_to};
            else
                act = {a_start, a_pc, a_fd, a_dx, a_xm, a_mw, a_fl, a_dxb, a_xmb, a_to};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b expected %b", e.tag, act, e.exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {fd_rs1, fd_rs2, dx_rd} = '0;
        {fd_uses_rs1, fd_uses_rs2, dx_is_load, dx_is_multdiv} = '0;
        {br_taken, md_ready, md_exception} = '0;

        // Reset state and idle run
        mcyc(1, 0, 0, 0, 0, 0, O_RUN, "reset");
        mcyc(1, 0, 0, 0, 0, 1, O_RUN, "reset8");
        mcyc(0, 0, 0, 0, 0, 0, O_RUN, "idle");

        // Load-use via rs2, then bubble removes the load: exactly one stall cycle
        step(0, 1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0, 0, O_LU,  "lu_rs2");
        step(0, 0, 5'd0, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0, 0, O_RUN, "lu_after");
        step(0, 1, 5'd9, 5'd9, 1, 5'd2, 0, 0, 0, 0, 0, 0, O_LU,  "lu_rs1");
        step(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0, O_RUN, "lu_r0");
        step(0, 1, 5'd5, 5'd5, 0, 5'd5, 0, 0, 0, 0, 0, 0, O_RUN, "lu_unused");
        step(0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 0, 0, 0, O_RUN, "lu_notload");

        // Branch overrides load-use; md_ready/exception ignored in RUN
        step(0, 1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 1, 0, 0, 0, O_BR,  "br_over_lu");
        mcyc(0, 0, 1, 0, 0, 0, O_BR,  "br_plain");
        mcyc(0, 0, 0, 1, 1, 0, O_RUN, "rdy_in_run");

        // Exception at wait cycle 3, branch during wait; multdiv beats branch and load-use
        step(0, 1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 1, 0, 0, 0, O_MDS, "md_prio");
        mcyc(0, 1, 0, 0, 0, 0, O_MDW, "exc_w1");
        mcyc(0, 1, 1, 0, 0, 0, O_MDW, "br_in_wait");
        mcyc(0, 1, 0, 0, 1, 0, O_REL, "exc_rel");
        mcyc(0, 0, 0, 0, 0, 0, O_RUN, "exc_after");

        // Multdiv normal: start cycle 0, md_ready at cycle 17
        mcyc(0, 1, 0, 0, 0, 0, O_MDS, "md_start");
        for (int i = 1; i <= 16; i++) mcyc(0, 1, 0, 0, 0, 0, O_MDW, "md_wait");
        mcyc(0, 1, 0, 1, 0, 0, O_REL, "md_rel");
        // Back-to-back multdiv starts normally
        mcyc(0, 1, 0, 0, 0, 0, O_MDS, "md_b2b");
        mcyc(0, 1, 0, 1, 0, 0, O_REL, "md_b2b_rel");
        mcyc(0, 0, 0, 0, 0, 0, O_RUN, "md_done");

        // Resynchronise both instances, then exercise the MD_TIMEOUT=8 watchdog
        mcyc(1, 0, 0, 0, 0, 1, O_RUN, "resync");
        mcyc(0, 1, 0, 0, 0, 1, O_MDS, "to_start");
        for (int i = 1; i <= 7; i++) mcyc(0, 1, 0, 0, 0, 1, O_MDW, "to_wait");
        mcyc(0, 1, 0, 0, 0, 1, O_TO,  "to_fire");
        mcyc(0, 0, 0, 0, 0, 1, O_RUN, "to_after");

        // Reset at wait cycle 4, then a fresh multdiv must get a full 8-cycle wait
        mcyc(0, 1, 0, 0, 0, 1, O_MDS, "rst_start");
        for (int i = 1; i <= 3; i++) mcyc(0, 1, 0, 0, 0, 1, O_MDW, "rst_wait");
        mcyc(1, 1, 0, 0, 0, 1, O_RUN, "rst_mid");
        mcyc(0, 0, 0, 0, 0, 1, O_RUN, "rst_run");
        mcyc(0, 1, 0, 0, 0, 1, O_MDS, "re_start");
        for (int i = 1; i <= 7; i++) mcyc(0, 1, 0, 0, 0, 1, O_MDW, "re_wait");
        mcyc(0, 1, 0, 0, 0, 1, O_TO,  "re_fire");

        // md_ready coinciding with the last wait cycle is a normal release
        mcyc(0, 1, 0, 0, 0, 1, O_MDS, "co_start");
        for (int i = 1; i <= 7; i++) mcyc(0, 1, 0, 0, 0, 1, O_MDW, "co_wait");
        mcyc(0, 1, 0, 1, 0, 1, O_REL, "co_rel");
        mcyc(0, 0, 0, 0, 0, 1, O_RUN, "co_after");

        // Let the monitor drain; leftover expectations count as failures
        @(posedge clock);
        @(posedge clock);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the write enables and squash controls of the PC register and the FD, DX, XM and MW pipeline latches. It handles three cases: load-use stalls, branch/jump flushes, and the multi-cycle multdiv unit's start/wait handshake, including a wait-timeout watchdog.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MD_WAIT before a forced release (must be >= 2)
CNT_W, 7, width of the internal multdiv wait counter (must hold MD_TIMEOUT)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
fd_rs1  in  5  source reg 1 of instruction in FD
fd_rs2  in  5  source reg 2 of instruction in FD
fd_uses_rs1  in  1  FD instruction reads rs1
fd_uses_rs2  in  1  FD instruction reads rs2
dx_rd  in  5  destination reg of instruction in DX
dx_is_load  in  1  DX instruction is lw
dx_is_multdiv  in  1  DX instruction is mul/div, awaiting execution
br_taken  in  1  branch/jump resolved taken in X this cycle
md_ready  in  1  multdiv result valid (one-cycle pulse)
md_exception  in  1  multdiv error (div by 0), one-cycle pulse
md_start  out  1  one-cycle pulse: multdiv latches operands
pc_wren  out  1  PC register write enable
fd_wren  out  1  FD latch write enable
dx_wren  out  1  DX latch write enable
xm_wren  out  1  XM latch write enable
mw_wren  out  1  MW latch write enable
fd_flush  out  1  FD latch loads nop
dx_bubble  out  1  DX latch loads nop (all ctrl bits 0)
xm_bubble  out  1  XM latch loads nop
md_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- FSM states: RUN, MD_WAIT. Internal wait counter wcnt[CNT_W-1:0].
- Reset:
  - state=RUN, wcnt=0.
  - md_start=0, md_timeout=0.
  - All wren=1; fd_flush, dx_bubble and xm_bubble=0.
  - Reset asserted in MD_WAIT aborts the wait; no md_start is issued on the reset cycle.
- Outputs are decoded from state plus current inputs (Mealy). Only state and wcnt are registered.
- RUN, default: all wren=1, all flush/bubble=0.
- RUN, load-use hazard:
  - Condition: dx_is_load && dx_rd!=0 && ((fd_uses_rs1 && fd_rs1==dx_rd) || (fd_uses_rs2 && fd_rs2==dx_rd)).
  - Response: pc_wren=0, fd_wren=0, dx_bubble=1; others default.
  - Exactly 1 stall cycle, because the bubble clears dx_is_load.
- RUN, br_taken=1: fd_flush=1, dx_bubble=1, pc_wren=1. br_taken overrides the load-use stall.
- RUN, dx_is_multdiv=1:
  - md_start=1 for one cycle; next state=MD_WAIT, wcnt<=0.
  - Same-cycle outputs are the MD_WAIT stall outputs.
  - Priority over br_taken and load-use.
- MD_WAIT stall outputs:
  - pc_wren, fd_wren, dx_wren=0.
  - xm_wren=1 with xm_bubble=1, so older instructions drain through XM/MW.
  - mw_wren=1; md_start=0.
  - wcnt increments each cycle.
- MD_WAIT release:
  - Trigger: md_ready=1, md_exception=1, or wcnt==MD_TIMEOUT-1.
  - Release cycle: all wren=1, all bubbles=0, so the result (or exception) is captured into XM.
  - Next state=RUN, wcnt<=0.
  - md_timeout=1 only when the release is due to the counter with md_ready=0 and md_exception=0.
- br_taken is ignored in MD_WAIT.
- md_ready or md_exception arriving in RUN is ignored.
- The release cycle allows DX to load the next instruction, so the same multdiv op never re-triggers. A back-to-back multdiv reaches DX one cycle later and starts normally.
- Register 0 never causes a hazard.

Optional Feature:
STALL_PERF_EN: when defined, adds two outputs:
- stall_cycles [31:0]: increments every cycle in which pc_wren=0.
- flush_count [31:0]: increments every cycle in which fd_flush=1.
- Both counters are cleared by reset and saturate at 32'hFFFFFFFF.

When STALL_PERF_EN is undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Load-use: dx_is_load=1, dx_rd=5, fd_rs2=5, fd_uses_rs2=1 -> exactly 1 cycle with pc_wren=0, fd_wren=0, dx_bubble=1. With dx_rd=0 -> no stall.
- Branch over load-use: br_taken=1 with the same load-use condition -> fd_flush=1, dx_bubble=1, pc_wren=1.
- Multdiv normal: dx_is_multdiv=1 at cycle 0, md_ready pulse at cycle 17:
  - md_start=1 on cycle 0 only.
  - Cycles 0-16: pc/fd/dx wren=0, xm_bubble=1.
  - Cycle 17: all wren=1; back in RUN.
- Multdiv timeout: MD_TIMEOUT=8, md_ready never asserted -> md_timeout=1 on the 8th MD_WAIT cycle, then RUN.
- md_exception at wait cycle 3 -> release on that cycle, md_timeout=0. br_taken during wait -> no fd_flush.
- Reset mid-wait: reset at wait cycle 4 -> next cycle RUN with all wren=1, md_start=0. A later multdiv restarts with wcnt=0.
